// File: rtl/des_pkg.sv
// Shared DES constants for the key-schedule / round-mixing slice.
// Contents:
//   perm_sel_e      selects which permutation a des_bit_permute instance applies
//   sched_state_e   key-schedule sequencer states
//   cd_t            56-bit C/D register type (C = upper 28 bits, D = lower 28)
//   PC1/PC2/E/P     FIPS-46 permutation tables, 1-based, entry = source DES bit
//   SHIFT_TBL       per-round left-rotation amounts of the key schedule
//   des_to_vec      DES bit number (1 = MSB) -> packed vector index
package des_pkg;

    typedef enum logic [1:0] {
        PERM_PC1,
        PERM_PC2,
        PERM_E,
        PERM_P
    } perm_sel_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } sched_state_e;

    typedef logic [55:0] cd_t;

    localparam int unsigned PC1_TBL [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TBL [1:48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int unsigned E_TBL [1:48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int unsigned P_TBL [1:32] = '{
        16,  7, 20, 21,
        29, 12, 28, 17,
         1, 15, 23, 26,
         5, 18, 31, 10,
         2,  8, 24, 14,
        32, 27,  3,  9,
        19, 13, 30,  6,
        22, 11,  4, 25
    };

    localparam int unsigned SHIFT_TBL [1:16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // Bit r set when round r+1 rotates by two; lets the datapath index the
    // schedule with a 4-bit round value.
    function automatic logic [15:0] shift_two_mask();
        logic [15:0] m;
        m = '0;
        for (int unsigned i = 1; i <= 16; i++) begin
            m[i-1] = (SHIFT_TBL[i] == 2);
        end
        return m;
    endfunction

    localparam logic [15:0] SHIFT_TWO = shift_two_mask();

    function automatic int unsigned des_to_vec(int unsigned width, int unsigned des_bit);
        return width - des_bit;
    endfunction

    function automatic int unsigned perm_entry(perm_sel_e sel, int unsigned k);
        case (sel)
            PERM_PC1: return PC1_TBL[k];
            PERM_PC2: return PC2_TBL[k];
            PERM_E:   return E_TBL[k];
            default:  return P_TBL[k];
        endcase
    endfunction

    // Rotate one 28-bit key half by one or two places.
    function automatic logic [27:0] rot_half(logic [27:0] h, logic right, logic two);
        logic [27:0] r;
        if (right) begin
            r = two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
        end else begin
            r = two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
        end
        return r;
    endfunction

    function automatic cd_t rotate_cd(cd_t cd, logic right, logic two);
        return {rot_half(cd[55:28], right, two), rot_half(cd[27:0], right, two)};
    endfunction

endpackage

// File: rtl/des_key_round_mixer_if.sv
// Bus bundle between the DES round controller and the key/round mixer.
//   master : round controller side (drives start/decrypt/key/r_half/sbox_out)
//   slave  : des_key_round_mixer side (drives subkey/mixed/p_out/round/valid/done)
interface des_key_round_mixer_if;
    import des_pkg::*;

    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic [31:0] r_half;
    logic [31:0] sbox_out;
    logic [47:0] subkey;
    logic [47:0] mixed;
    logic [31:0] p_out;
    logic [3:0]  round;
    logic        valid;
    logic        done;

    modport master (
        output start, decrypt, key, r_half, sbox_out,
        input  subkey, mixed, p_out, round, valid, done
    );

    modport slave (
        input  start, decrypt, key, r_half, sbox_out,
        output subkey, mixed, p_out, round, valid, done
    );

endinterface

// File: rtl/des_bit_permute.sv
// Fixed DES bit permutation, purely combinational wiring.
// Parameters:
//   IN_W, OUT_W  input / output widths
//   SEL          which FIPS-46 table to apply (PC1, PC2, E or P)
// Ports:
//   din   IN_W-bit source, bit IN_W-1 is DES bit 1
//   dout  OUT_W-bit result, output DES bit k taken from input DES bit TABLE[k]
module des_bit_permute
    import des_pkg::*;
#(
    parameter int unsigned IN_W  = 64,
    parameter int unsigned OUT_W = 56,
    parameter perm_sel_e   SEL   = PERM_PC1
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    for (genvar k = 1; k <= OUT_W; k++) begin : g_bit
        localparam int unsigned DST = des_to_vec(OUT_W, k);
        localparam int unsigned SRC = des_to_vec(IN_W, perm_entry(SEL, k));
        assign dout[DST] = din[SRC];
    end

    // PC-1 drops the key parity bits; fold the whole input into a sink so
    // the dropped bits are visibly intentional.
    logic unused_din;
    assign unused_din = ^din;

endmodule

// File: rtl/des_key_round_mixer.sv
// Iterative DES key schedule plus round-mixing datapath.
// After an accepted start the C/D register steps once per clock, presenting
// one 48-bit subkey per cycle for 16 rounds in encrypt or decrypt order.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   slave modport: start/decrypt/key/r_half/sbox_out in,
//         subkey/mixed/p_out/round/valid/done out
// mixed = E(r_half) ^ subkey and p_out = P(sbox_out) are combinational.
module des_key_round_mixer
    import des_pkg::*;
#(
    parameter int unsigned NROUNDS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    des_key_round_mixer_if.slave         bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

    sched_state_e state_q, state_d;
    cd_t          cd_q, cd_d;
    cd_t          cd_pc1;
    logic [3:0]   round_q, round_d;
    logic         dec_q, dec_d;
    logic [47:0]  subkey_w;
    logic [47:0]  e_r;
    logic [31:0]  p_w;

    des_bit_permute #(.IN_W(64), .OUT_W(56), .SEL(PERM_PC1)) u_pc1 (
        .din  (bus.key),
        .dout (cd_pc1)
    );

    des_bit_permute #(.IN_W(56), .OUT_W(48), .SEL(PERM_PC2)) u_pc2 (
        .din  (cd_q),
        .dout (subkey_w)
    );

    des_bit_permute #(.IN_W(32), .OUT_W(48), .SEL(PERM_E)) u_e (
        .din  (bus.r_half),
        .dout (e_r)
    );

    des_bit_permute #(.IN_W(32), .OUT_W(32), .SEL(PERM_P)) u_p (
        .din  (bus.sbox_out),
        .dout (p_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cd_q    <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            round_q <= round_d;
            dec_q   <= dec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        round_d = round_q;
        dec_d   = dec_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    round_d = '0;
                    dec_d   = bus.decrypt;
                    // Decrypt starts from C16D16, which equals C0D0.
                    cd_d    = bus.decrypt ? cd_pc1
                                          : rotate_cd(cd_pc1, 1'b0, SHIFT_TWO[0]);
                end
            end
            ST_RUN: begin
                if (round_q == LAST_ROUND) begin
                    state_d = ST_IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                    // Stepping into round j = round_q+2: encrypt uses SHIFT[j]
                    // (mask bit round_q+1), decrypt undoes SHIFT[18-j]
                    // (mask bit 15-round_q).
                    cd_d = dec_q ? rotate_cd(cd_q, 1'b1, SHIFT_TWO[4'd15 - round_q])
                                 : rotate_cd(cd_q, 1'b0, SHIFT_TWO[round_q + 4'd1]);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.subkey = subkey_w;
    assign bus.mixed  = e_r ^ subkey_w;
    assign bus.p_out  = p_w;
    assign bus.round  = round_q;
    assign bus.valid  = (state_q == ST_RUN);
    assign bus.done   = (state_q == ST_RUN) && (round_q == LAST_ROUND);

endmodule

// File: tb/tb_des_key_round_mixer.sv
// Self-checking bench for des_key_round_mixer.
// The reference model recomputes the DES key schedule from scratch for every
// requested subkey (PC-1, cumulative left shifts, PC-2) with its own tables.
module tb_des_key_round_mixer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    des_key_round_mixer_if bus();

    des_key_round_mixer #(.NROUNDS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam int T_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int T_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int T_E [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int T_P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    int passed = 0;
    int total  = 0;

    logic [47:0] sk_log [1:16];
    logic [47:0] mix_first;
    logic [31:0] p_first;

    function automatic logic [63:0] perm(input logic [63:0] x, input int in_w,
                                         input int out_w, input int sel);
        logic [63:0] r;
        int src;
        r = '0;
        for (int k = 0; k < out_w; k++) begin
            case (sel)
                0:       src = T_PC1[k];
                1:       src = T_PC2[k];
                2:       src = T_E[k];
                default: src = T_P[k];
            endcase
            r[6'(out_w - 1 - k)] = x[6'(in_w - src)];
        end
        return r;
    endfunction

    function automatic logic [47:0] e_model(input logic [31:0] r);
        logic [63:0] t;
        t = perm({32'h0, r}, 32, 48, 2);
        return t[47:0];
    endfunction

    function automatic logic [31:0] p_model(input logic [31:0] s);
        logic [63:0] t;
        t = perm({32'h0, s}, 32, 32, 3);
        return t[31:0];
    endfunction

    // Standard key schedule: K_idx = PC2(C_idx D_idx), C_i = C_{i-1} <<< SHIFT[i].
    function automatic logic [47:0] model_subkey(input logic [63:0] k, input int idx);
        logic [63:0] cd;
        logic [27:0] c, d;
        logic [63:0] t;
        cd = perm(k, 64, 56, 0);
        c  = cd[55:28];
        d  = cd[27:0];
        for (int i = 0; i < idx; i++) begin
            for (int s = 0; s < T_SH[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        end
        t = perm({8'h0, c, d}, 56, 48, 1);
        return t[47:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Entered at a falling edge; issues start, checks all 16 rounds and the
    // idle cycle after, returning at a falling edge (+1) ready for the next start.
    // restart_at: round during which a second (ignored) start is pulsed.
    // abort_at:   round during which rst is asserted; the run ends there.
    task automatic run_sched(input logic [63:0] k, input logic dec,
                             input int restart_at, input int abort_at,
                             input logic use_dir, input logic [31:0] dir_r,
                             input logic [31:0] dir_s);
        logic [47:0] exp_sk;
        logic [31:0] r, s;
        bus.key     = k;
        bus.decrypt = dec;
        bus.start   = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.key     = k;
            bus.decrypt = dec;
            if (n <= 16) begin
                exp_sk = model_subkey(k, dec ? 17 - n : n);
                chk("valid", 64'(bus.valid), 64'(1));
                chk("round", 64'(bus.round), 64'(n - 1));
                chk("done", 64'(bus.done), 64'(n == 16));
                chk("subkey", 64'(bus.subkey), 64'(exp_sk));
                sk_log[n] = bus.subkey;
            end else begin
                exp_sk = model_subkey(k, dec ? 1 : 16);
                chk("valid_after", 64'(bus.valid), 64'(0));
                chk("done_after", 64'(bus.done), 64'(0));
                chk("round_hold", 64'(bus.round), 64'(15));
                chk("subkey_hold", 64'(bus.subkey), 64'(exp_sk));
            end
            if (use_dir && n == 1) begin
                r = dir_r;
                s = dir_s;
            end else begin
                r = $urandom();
                s = $urandom();
            end
            bus.r_half   = r;
            bus.sbox_out = s;
            #1;
            chk("mixed", 64'(bus.mixed), 64'(e_model(r) ^ exp_sk));
            chk("p_out", 64'(bus.p_out), 64'(p_model(s)));
            if (n == 1) begin
                mix_first = bus.mixed;
                p_first   = bus.p_out;
            end
            if (n == restart_at) begin
                bus.start   = 1'b1;
                bus.key     = ~k;
                bus.decrypt = ~dec;
            end
            if (n == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_valid", 64'(bus.valid), 64'(0));
                chk("abort_done", 64'(bus.done), 64'(0));
                chk("abort_round", 64'(bus.round), 64'(0));
                chk("abort_subkey", 64'(bus.subkey), 64'(0));
                chk("abort_mixed", 64'(bus.mixed), 64'(e_model(r)));
                bus.start = 1'b1;
                @(posedge clk);
                #1;
                chk("rst_beats_start", 64'(bus.valid), 64'(0));
                @(negedge clk);
                rst       = 1'b0;
                bus.start = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        logic [63:0] k;
        bus.start    = 1'b0;
        bus.decrypt  = 1'b0;
        bus.key      = '0;
        bus.r_half   = '0;
        bus.sbox_out = '0;

        repeat (2) @(negedge clk);
        chk("reset_valid", 64'(bus.valid), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));
        chk("reset_round", 64'(bus.round), 64'(0));
        chk("reset_subkey", 64'(bus.subkey), 64'(0));
        rst = 1'b0;

        // Reference key, encrypt order, directed mixing inputs in round 1.
        run_sched(64'h133457799BBCDFF1, 1'b0, 0, 0, 1'b1, 32'hF0AAF0AA, 32'h5C82B597);
        chk("enc_k1", 64'(sk_log[1]), 64'h1B02EFFC7072);
        chk("enc_k2", 64'(sk_log[2]), 64'h79AED9DBC9E5);
        chk("enc_k16", 64'(sk_log[16]), 64'hCB3D8B0E17F5);
        chk("mixed_ref", 64'(mix_first), 64'h6117BA866527);
        chk("p_out_ref", 64'(p_first), 64'h234AA9BB);

        // Same key, decrypt order; started in the idle cycle right after round 16.
        run_sched(64'h133457799BBCDFF1, 1'b1, 0, 0, 1'b0, 32'h0, 32'h0);
        chk("dec_first", 64'(sk_log[1]), 64'hCB3D8B0E17F5);
        chk("dec_last", 64'(sk_log[16]), 64'h1B02EFFC7072);

        // Second start during round 5 must not disturb the schedule.
        run_sched(64'h133457799BBCDFF1, 1'b0, 5, 0, 1'b0, 32'h0, 32'h0);
        chk("restart_k16", 64'(sk_log[16]), 64'hCB3D8B0E17F5);

        // Reset during round 8, then a clean schedule.
        k = {$urandom(), $urandom()};
        run_sched(k, 1'b0, 0, 8, 1'b0, 32'h0, 32'h0);
        k = {$urandom(), $urandom()};
        run_sched(k, 1'b0, 0, 0, 1'b0, 32'h0, 32'h0);

        // All-zero key: every subkey is zero, mixed is plain E(r_half).
        run_sched(64'h0, 1'b0, 0, 0, 1'b1, 32'hFFFFFFFF, 32'h0);
        chk("zero_key_mixed", 64'(mix_first), 64'hFFFFFFFFFFFF);
        chk("zero_key_k9", 64'(sk_log[9]), 64'h0);

        // Random keys in both orders.
        for (int i = 0; i < 4; i++) begin
            k = {$urandom(), $urandom()};
            run_sched(k, 1'($urandom_range(1, 0)), 0, 0, 1'b0, 32'h0, 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
